seq_addsub_chunked: RTL and testbench
=====================================

Name: seq_addsub_chunked

Overview:
Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, carrying between chunks in a register, so wide adds are area-cheap. It sits beside the combinational ripple-carry adders in the datapath library. It adds a start/done handshake, a subtract mode, and a signed overflow flag.

Parameters:
WIDTH, 16, operand/result width in bits
CHUNK, 4, bits processed per cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise); CHUNK == WIDTH is legal

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
A  input  WIDTH  operand A, sampled on the accepted start edge
B  input  WIDTH  operand B, sampled on the accepted start edge
cin  input  1  carry-in for add mode, sampled with start; ignored when sub=1
sub  input  1  0: S=A+B+cin; 1: S=A-B (two's complement), sampled with start
ready  output  1  high in IDLE and DONE states
busy  output  1  high in RUN state
done  output  1  one-cycle pulse; result outputs valid from this cycle
S  output  WIDTH  result, registered
cout  output  1  final carry out (sub mode: 1 = no borrow)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, chunk counter=0, internal carry=0. S=0, cout=0, ovf=0, done=0, busy=0, ready=1. Reset mid-RUN aborts the operation; no done pulse follows.
- N = WIDTH/CHUNK. The counter is ceil(log2(N+1)) bits minimum.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE, start=1: latch A; latch B, inverted if sub=1; set carry = sub ? 1 : cin; clear the counter; go to RUN.
  - IDLE, start=0: stay in IDLE.
  - DONE, start=0: go to IDLE.
  - RUN: each edge adds slice k of A and B plus carry, writes the sum slice into the internal result register, updates the carry, and increments k.
  - RUN, slice N-1: also computes ovf from the carries into and out of the MSB. Copies the internal result to S and the carry to cout, then goes to DONE.
- done=1 only while in DONE, for exactly one cycle.
- Latency: start accepted at edge t, so done=1 in the cycle after edge t+N. Back-to-back throughput is one op per N+1 cycles, because start is accepted during the DONE cycle.
- S, cout and ovf change only on entry to DONE. They hold their values through IDLE and the next RUN until the next DONE. Partial sums are never visible on S.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- Arithmetic is unsigned modulo 2^WIDTH for S. ovf is computed in both modes and is valid for signed interpretation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=16, CHUNK=4. A=65000, B=65340, cin=0, sub=0, one-cycle start -> done pulses exactly 4 cycles after the start edge; S=64804, cout=1, ovf=0; S holds after done drops.
- sub=1: A=1005, B=69 -> S=936, cout=1. Then back-to-back start during the DONE cycle with A=50, B=10024, sub=1 -> S=55562, cout=0; second done arrives 5 cycles after the first.
- A=16'h7FFF, B=16'h0001, cin=0, sub=0 -> S=16'h8000, ovf=1, cout=0. Then A=16'h8000, B=16'h8000 -> S=0, cout=1, ovf=1.
- Start with A=15124, B=5383, cin=1; assert start again with different operands during RUN -> second start ignored, S=20508. Then start a new op and assert rst 2 cycles in -> no done pulse; S=0, cout=0, ovf=0, ready=1 next cycle.
- WIDTH=32, CHUNK=8: A=32'hFFFFFFFF, B=1, cin=0 -> S=0, cout=1, done 4 cycles after start. WIDTH=16, CHUNK=16: A=1005, B=69, cin=1 -> S=1075, done 1 cycle after start.

Source files
------------

// File: rtl/seq_addsub_chunked_if.sv
// Start/done handshake and operand/result bus for the chunked adder.
// The master issues operands; the slave is the arithmetic unit.
interface seq_addsub_chunked_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;

    modport master (
        output start, A, B, cin, sub,
        input  ready, busy, done, S, cout, ovf
    );

    modport slave (
        input  start, A, B, cin, sub,
        output ready, busy, done, S, cout, ovf
    );
endinterface

// File: rtl/seq_addsub_chunked.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a carry register.
// Result, carry-out and signed overflow update only on entry to DONE.
module seq_addsub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_addsub_chunked_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [CW-1:0]    r_k;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic [CHUNK-1:0] w_sum;
    logic             w_co;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;

    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k == CW'(i)) begin
                w_sa = r_a[i*CHUNK +: CHUNK];
                w_sb = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign {w_co, w_sum} = {1'b0, w_sa} + {1'b0, w_sb}
                         + {{CHUNK{1'b0}}, r_carry};

    // Carry into the MSB recovered from the top sum bit of the slice
    assign w_cmsb = w_sa[CHUNK-1] ^ w_sb[CHUNK-1] ^ w_sum[CHUNK-1];
    assign w_last = (r_k == LAST);

    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < N; i++) begin
            if (r_k == CW'(i)) begin
                w_acc_nxt[i*CHUNK +: CHUNK] = w_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.sub ? ~bus.B : bus.B;
                        r_carry <= bus.sub | bus.cin;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_co;
                    r_k     <= r_k + CW'(1);
                    if (w_last) begin
                        r_s     <= w_acc_nxt;
                        r_cout  <= w_co;
                        r_ovf   <= w_cmsb ^ w_co;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready = r_state[0] | r_state[2];
    assign bus.busy  = r_state[1];
    assign bus.done  = r_state[2];
    assign bus.S     = r_s;
    assign bus.cout  = r_cout;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Scoreboard bench for seq_addsub_chunked in three configurations.
// Issue pushes expected results; negedge monitors pop on done.
module tb_seq_addsub_chunked;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_addsub_chunked_if #(.WIDTH(16)) bus0 ();
    seq_addsub_chunked_if #(.WIDTH(32)) bus1 ();
    seq_addsub_chunked_if #(.WIDTH(16)) bus2 ();

    seq_addsub_chunked #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    seq_addsub_chunked #(.WIDTH(32), .CHUNK(8)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    seq_addsub_chunked #(.WIDTH(16), .CHUNK(16)) u2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic on_done(int d, logic [31:0] s, logic c, logic v);
        exp_t e;
        int   sz;
        case (d)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            fail_now($sformatf("d%0d unexpected done", d));
            return;
        end
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("d%0d S", d), s, e.s);
        chk($sformatf("d%0d cout", d), {31'd0, c}, {31'd0, e.c});
        chk($sformatf("d%0d ovf", d), {31'd0, v}, {31'd0, e.v});
        chk($sformatf("d%0d done cycle", d), cyc, e.at);
    endtask

    always @(negedge clk)
        if (bus0.done === 1'b1) on_done(0, 32'(bus0.S), bus0.cout, bus0.ovf);
    always @(negedge clk)
        if (bus1.done === 1'b1) on_done(1, bus1.S, bus1.cout, bus1.ovf);
    always @(negedge clk)
        if (bus2.done === 1'b1) on_done(2, 32'(bus2.S), bus2.cout, bus2.ovf);

    function automatic logic rdy(int d);
        case (d)
            0:       return bus0.ready;
            1:       return bus1.ready;
            default: return bus2.ready;
        endcase
    endfunction

    task automatic drive(int d, logic st, logic [31:0] a, logic [31:0] b,
                         logic ci, logic su);
        case (d)
            0: begin
                bus0.start = st; bus0.A = a[15:0]; bus0.B = b[15:0];
                bus0.cin = ci; bus0.sub = su;
            end
            1: begin
                bus1.start = st; bus1.A = a; bus1.B = b;
                bus1.cin = ci; bus1.sub = su;
            end
            default: begin
                bus2.start = st; bus2.A = a[15:0]; bus2.B = b[15:0];
                bus2.cin = ci; bus2.sub = su;
            end
        endcase
    endtask

    task automatic set_start(int d, logic st);
        case (d)
            0:       bus0.start = st;
            1:       bus1.start = st;
            default: bus2.start = st;
        endcase
    endtask

    // Returns #1 after the edge that accepted the start
    task automatic issue(int d, logic [31:0] a, logic [31:0] b,
                         logic ci, logic su, logic [31:0] es,
                         logic ec, logic ev, int n, bit push);
        exp_t e;
        int   k = 0;
        while (!rdy(d) && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!rdy(d)) fail_now($sformatf("d%0d ready timeout", d));
        drive(d, 1'b1, a, b, ci, su);
        @(posedge clk); #1;
        set_start(d, 1'b0);
        if (push) begin
            e.s = es; e.c = ec; e.v = ev; e.at = cyc + n;
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic drain(int d);
        int k = 0;
        int sz;
        do begin
            case (d)
                0:       sz = q0.size();
                1:       sz = q1.size();
                default: sz = q2.size();
            endcase
            if (sz > 0) begin
                @(posedge clk); #1; k++;
            end
        end while (sz > 0 && k < 200);
        if (sz > 0) begin
            fail_now($sformatf("d%0d done timeout", d));
            case (d)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
    endtask

    task automatic wait_done0();
        int k = 0;
        while (bus0.done !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (bus0.done !== 1'b1) fail_now("d0 wait done timeout");
    endtask

    initial begin
        drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
        drive(2, 1'b0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", {31'd0, bus0.ready}, 32'd1);
        chk("rst busy", {31'd0, bus0.busy}, 32'd0);
        chk("rst done", {31'd0, bus0.done}, 32'd0);
        chk("rst S", 32'(bus0.S), 32'd0);
        chk("rst cout", {31'd0, bus0.cout}, 32'd0);
        chk("rst ovf", {31'd0, bus0.ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned add with carry out; latency and hold
        issue(0, 65000, 65340, 1'b0, 1'b0, 64804, 1'b1, 1'b0, 4, 1'b1);
        chk("run busy", {31'd0, bus0.busy}, 32'd1);
        chk("run ready", {31'd0, bus0.ready}, 32'd0);
        chk("run S no partial", 32'(bus0.S), 32'd0);
        drain(0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold S", 32'(bus0.S), 32'd64804);
        chk("hold done", {31'd0, bus0.done}, 32'd0);
        chk("hold ready", {31'd0, bus0.ready}, 32'd1);

        // Subtract, then back-to-back start during DONE
        issue(0, 1005, 69, 1'b0, 1'b1, 936, 1'b1, 1'b0, 4, 1'b1);
        wait_done0();
        issue(0, 50, 10024, 1'b0, 1'b1, 55562, 1'b0, 1'b0, 4, 1'b1);
        drain(0);

        // Signed overflow cases
        issue(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0,
              32'h8000, 1'b0, 1'b1, 4, 1'b1);
        issue(0, 32'h8000, 32'h8000, 1'b0, 1'b0,
              32'h0000, 1'b1, 1'b1, 4, 1'b1);
        drain(0);

        // Start during RUN must be ignored
        issue(0, 15124, 5383, 1'b1, 1'b0, 20508, 1'b0, 1'b0, 4, 1'b1);
        drive(0, 1'b1, 1, 2, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        drain(0);

        // Reset two cycles into an operation aborts it
        issue(0, 1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort S", 32'(bus0.S), 32'd0);
        chk("abort cout", {31'd0, bus0.cout}, 32'd0);
        chk("abort ovf", {31'd0, bus0.ovf}, 32'd0);
        chk("abort ready", {31'd0, bus0.ready}, 32'd1);
        chk("abort busy", {31'd0, bus0.busy}, 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // 32-bit, 8-bit chunks
        issue(1, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 1'b1);
        drain(1);
        issue(1, 0, 1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 1'b1);
        drain(1);

        // Single-chunk configuration
        issue(2, 1005, 69, 1'b1, 1'b0, 1075, 1'b0, 1'b0, 1, 1'b1);
        drain(2);
        issue(2, 1005, 69, 1'b0, 1'b1, 936, 1'b1, 1'b0, 1, 1'b1);
        drain(2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
